// File: rtl/m31_pkg.sv
// rtl/m31_pkg.sv - shared types, modulus and canonicalise helper for M31 arithmetic
package m31_pkg;

    localparam logic [30:0] M31_P = 31'h7FFFFFFF;

    typedef logic [30:0] m31_t;
    typedef logic [61:0] m31_wide_t;

    // Conditional subtract of p from a value in [0, 2^31]. Working in 31 bits
    // is enough: u = 2^31 wraps to 0 in the low bits, and 0 - p mod 2^31 = 1.
    function automatic m31_t m31_canon(input logic [31:0] u);
        m31_t r;
        if (u >= {1'b0, M31_P}) begin
            r = u[30:0] - M31_P;
        end else begin
            r = u[30:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/m31_fold_canon.sv
// rtl/m31_fold_canon.sv - combinational 62-bit to canonical M31 reduction
module m31_fold_canon
    import m31_pkg::*;
(
    input  m31_wide_t prod,
    output m31_t      res
);

    logic [31:0] t;
    logic [31:0] u;

    // Two folds using 2^31 == 1 (mod p), then a single conditional subtract.
    always_comb begin
        t   = {1'b0, prod[30:0]} + {1'b0, prod[61:31]};
        u   = {1'b0, t[30:0]} + {31'b0, t[31]};
        res = m31_canon(u);
    end

endmodule

// File: rtl/m31_mul_pipe.sv
// rtl/m31_mul_pipe.sv - three-stage M31 modular multiplier with valid/ready streaming
module m31_mul_pipe
    import m31_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [30:0]      in_a,
    input  logic [30:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [30:0]      out_res,
    output logic [TAG_W-1:0] out_tag
);

    // S1: operand capture
    logic             v1_q, v1_d;
    m31_t             a1_q, a1_d;
    m31_t             b1_q, b1_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;
    // S2: full product
    logic             v2_q, v2_d;
    m31_wide_t        prod2_q, prod2_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;
    // S3: reduced result
    logic             v3_q, v3_d;
    m31_t             res3_q, res3_d;
    logic [TAG_W-1:0] tag3_q, tag3_d;

    logic adv1, adv2, adv3;
    m31_t fold_res;

    m31_fold_canon u_fold (
        .prod (prod2_q),
        .res  (fold_res)
    );

    // Advance chain: a stage moves when empty or when its successor moves,
    // so bubbles collapse while later stages are stalled.
    always_comb begin
        adv3 = !v3_q || out_ready;
        adv2 = !v2_q || adv3;
        adv1 = !v1_q || adv2;
    end

    assign in_ready  = adv1 && !rst;
    assign out_valid = v3_q;
    assign out_res   = res3_q;
    assign out_tag   = tag3_q;

    // Next-state for all stages; data only loads when valid data arrives.
    always_comb begin
        v1_d    = v1_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        tag1_d  = tag1_q;
        v2_d    = v2_q;
        prod2_d = prod2_q;
        tag2_d  = tag2_q;
        v3_d    = v3_q;
        res3_d  = res3_q;
        tag3_d  = tag3_q;

        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                a1_d   = in_a;
                b1_d   = in_b;
                tag1_d = in_tag;
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                prod2_d = m31_wide_t'(a1_q) * m31_wide_t'(b1_q);
                tag2_d  = tag1_q;
            end
        end

        if (adv3) begin
            v3_d = v2_q;
            if (v2_q) begin
                res3_d = fold_res;
                tag3_d = tag2_q;
            end
        end
    end

    // Pipeline registers; reset discards every in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            tag1_q  <= '0;
            v2_q    <= 1'b0;
            prod2_q <= '0;
            tag2_q  <= '0;
            v3_q    <= 1'b0;
            res3_q  <= '0;
            tag3_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            tag1_q  <= tag1_d;
            v2_q    <= v2_d;
            prod2_q <= prod2_d;
            tag2_q  <= tag2_d;
            v3_q    <= v3_d;
            res3_q  <= res3_d;
            tag3_q  <= tag3_d;
        end
    end

endmodule

// File: tb/tb_m31_mul_pipe.sv
// tb/tb_m31_mul_pipe.sv - self-checking bench for m31_mul_pipe
module tb_m31_mul_pipe;

    localparam int TAG_W = 4;
    localparam longint unsigned P = 64'h7FFFFFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [30:0]      in_a;
    logic [30:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [30:0]      out_res;
    logic [TAG_W-1:0] out_tag;

    m31_mul_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [30:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   out_cnt  = 0;
    int   run_len  = 0;
    int   max_run  = 0;
    logic             prev_stall = 1'b0;
    logic [30:0]      prev_res;
    logic [TAG_W-1:0] prev_tag;

    function automatic logic [30:0] ref_mul(input logic [30:0] a, input logic [30:0] b);
        longint unsigned aa, bb;
        aa = longint'(a) % P;
        bb = longint'(b) % P;
        return 31'((aa * bb) % P);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard: handshakes seen at negedge complete on the following posedge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            run_len    = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_res", 64'(out_res), 64'(prev_res));
                chk("hold_tag", 64'(out_tag), 64'(prev_tag));
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_res;
            prev_tag   = out_tag;
            if (out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                chk("res_range", 64'(out_res < 31'h7FFFFFFF), 64'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_res", 64'(out_res), 64'(e.res));
                    chk("sb_tag", 64'(out_tag), 64'(e.tag));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back('{ref_mul(in_a, in_b), in_tag});
        end
    end

    task automatic push(input logic [30:0] a, input logic [30:0] b, input logic [TAG_W-1:0] tag);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("push_accept", 64'(ok), 64'd1);
    endtask

    task automatic run_one(input logic [30:0] a, input logic [30:0] b,
                           input logic [TAG_W-1:0] tag, input logic [30:0] exp);
        int lat;
        lat = 0;
        push(a, b, tag);
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid) lat = k;
        end
        chk("dir_latency", 64'(lat), 64'd3);
        chk("dir_res", 64'(out_res), 64'(exp));
        chk("dir_tag", 64'(out_tag), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [30:0] pa[5];
        logic [30:0] pb[5];
        logic [30:0] hold_res;
        int acc, base, sent, cyc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_res", 64'(out_res), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed arithmetic corners
        run_one(31'h7FFFFFFE, 31'h7FFFFFFE, 4'd3, 31'd1);
        run_one(31'h40000000, 31'd2,        4'd1, 31'd1);
        run_one(31'h7FFFFFFF, 31'd1,        4'd2, 31'd0);
        run_one(31'h7FFFFFFF, 31'h7FFFFFFF, 4'd4, 31'd0);
        run_one(31'd0,        31'h12345678, 4'd5, 31'd0);
        run_one(31'd3,        31'd5,        4'd6, 31'd15);

        // Back-to-back stream of 16
        max_run  = 0;
        base     = out_cnt;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_a   = 31'($urandom());
            in_b   = 31'($urandom());
            in_tag = 4'(i);
            @(negedge clk);
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("stream_run", 64'(max_run), 64'd16);
        chk("stream_count", 64'(out_cnt - base), 64'd16);

        // Backpressure: capacity of three
        for (int i = 0; i < 5; i++) begin
            pa[i] = 31'($urandom());
            pb[i] = 31'($urandom());
        end
        base      = out_cnt;
        out_ready = 1'b0;
        acc       = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (acc < 5);
            in_a     = pa[acc % 5];
            in_b     = pb[acc % 5];
            in_tag   = 4'(8 + acc);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 64'(acc), 64'd3);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        hold_res = out_res;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_res_stable", 64'(out_res), 64'(hold_res));
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 5; c++) begin
            in_valid = 1'b1;
            in_a     = pa[acc];
            in_b     = pb[acc];
            in_tag   = 4'(8 + acc);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        chk("bp_delivered", 64'(out_cnt - base), 64'd5);

        // Random 50% traffic, 10k operations
        base = out_cnt;
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_a      = 31'($urandom());
            in_b      = 31'($urandom());
            in_tag    = 4'($urandom());
            if ($urandom_range(0, 15) == 0) in_a = 31'h7FFFFFFF;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rand_sent", 64'(sent), 64'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_count", 64'(out_cnt - base), 64'(sent));

        // Asynchronous reset with three operations in flight
        out_ready = 1'b0;
        push(31'd11, 31'd13, 4'd1);
        push(31'd17, 31'd19, 4'd2);
        push(31'd23, 31'd29, 4'd3);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        base      = out_cnt;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_no_stale", 64'(out_cnt - base), 64'd0);
        run_one(31'd2, 31'd3, 4'd7, 31'd6);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
